// File: rtl/mem_bist_ctrl.sv
// Write/read-back self test sequencer for a single-port block RAM.
// Fills every word with a pattern, reads it back, counts mismatches.
module mem_bist_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65536,
  parameter int ERR_W     = 16,
  parameter logic [WORD_SIZE-1:0] SEED = 16'hA5C3
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           pattern_sel,
  output logic                 mem_ena,
  output logic                 mem_wea,
  output logic [ADDR_W-1:0]    mem_addra,
  output logic [WORD_SIZE-1:0] mem_dina,
  input  logic [WORD_SIZE-1:0] mem_douta,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             sel_q, sel_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [ADDR_W-1:0]      ferr_q, ferr_d;
  logic                   vld_q, vld_d;
  logic [WORD_SIZE-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]      kad_q, kad_d;

  function automatic logic [WORD_SIZE-1:0] pat(
    input logic [1:0]        s,
    input logic [ADDR_W-1:0] a
  );
    logic [WORD_SIZE-1:0] r;
    case (s)
      2'd0:    r = WORD_SIZE'(a);
      2'd1:    r = ~WORD_SIZE'(a);
      2'd2:    r = a[0] ? WORD_SIZE'(16'h5555) : WORD_SIZE'(16'hAAAA);
      default: r = SEED;
    endcase
    return r;
  endfunction

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      vld_q   <= 1'b0;
      exp_q   <= '0;
      kad_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      kad_q   <= kad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    vld_d     = 1'b0;
    exp_d     = exp_q;
    kad_d     = kad_q;
    mem_ena   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = '0;

    // Read data lags the address by one cycle; compare the piped expectation
    if (vld_q && !abort && (mem_douta != exp_q)) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (err_q == '0) ferr_d = kad_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d = S_WRITE;
          addr_d  = '0;
          sel_d   = pattern_sel;
          err_d   = '0;
          ferr_d  = '0;
        end
      end
      S_WRITE: begin
        mem_ena   = 1'b1;
        mem_wea   = 1'b1;
        mem_addra = addr_q;
        mem_dina  = pat(sel_q, addr_q);
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (addr_q == LAST) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        mem_ena   = 1'b1;
        mem_addra = addr_q;
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          vld_d = 1'b1;
          exp_d = pat(sel_q, addr_q);
          kad_d = addr_q;
          if (addr_q == LAST) begin
            state_d = S_DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d = abort ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_READ)
                       || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_q == '0);
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: 16-word RAM model with read corruption,
// cycle-level expectation model and directed scenarios.
module tb_mem_bist_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        mem_ena, mem_wea;
  logic [15:0] mem_addra, mem_dina, mem_douta;
  logic        busy, done, pass;
  logic [2:0]  err_cnt;
  logic [15:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(
    .WORD_SIZE(16), .ADDR_W(16), .DEPTH(DEPTH), .ERR_W(3), .SEED(16'hA5C3)
  ) dut (
    .clka(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_sel(pattern_sel),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  // RAM: registered read, bit 0 flipped on addresses marked corrupt
  logic [15:0] ram [DEPTH];
  logic [15:0] rdata_q = 16'h0;
  logic [3:0]  raddr_q = 4'h0;
  logic [DEPTH-1:0] corrupt = '0;

  initial for (int i = 0; i < DEPTH; i++) ram[i] = 16'h0;

  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wea) ram[mem_addra[3:0]] <= mem_dina;
      rdata_q <= ram[mem_addra[3:0]];
      raddr_q <= mem_addra[3:0];
    end
  end
  assign mem_douta = rdata_q ^ {15'b0, corrupt[raddr_q]};

  function automatic logic [15:0] pattern(input logic [1:0] s, input int a);
    logic [15:0] av;
    av = a[15:0];
    case (s)
      2'd0:    return av;
      2'd1:    return ~av;
      2'd2:    return av[0] ? 16'h5555 : 16'hAAAA;
      default: return 16'hA5C3;
    endcase
  endfunction

  // Model: ms 0=idle 1=running 2=done; t counts edges since accepted start
  int          ms = 0;
  int          t = 0;
  int          m_err = 0;
  int          m_ferr = 0;
  logic [1:0]  m_sel = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms = 0; t = 0; m_err = 0; m_ferr = 0; m_sel = 2'd0;
    end else if (ms == 1) begin
      if (abort) ms = 0;
      else begin
        t++;
        if (t >= DEPTH + 2 && t <= 2 * DEPTH + 1) begin
          if (corrupt[t - DEPTH - 2]) begin
            if (m_err == 0) m_ferr = t - DEPTH - 2;
            if (m_err != 7) m_err++;
          end
        end
        if (t == 2 * DEPTH + 1) ms = 2;
      end
    end else if (start && !abort) begin
      ms = 1; t = 0; m_sel = pattern_sel; m_err = 0; m_ferr = 0;
    end
  end

  logic        e_ena, e_wea, e_busy, e_done, e_pass;
  logic [15:0] e_addr, e_dina;

  always @(negedge clk) begin
    if (!rst) begin
      e_ena = 0; e_wea = 0; e_addr = 0; e_dina = 0;
      e_busy = (ms == 1);
      e_done = (ms == 2);
      e_pass = (ms == 2) && (m_err == 0);
      if (ms == 1 && t < DEPTH) begin
        e_ena = 1; e_wea = 1; e_addr = t[15:0]; e_dina = pattern(m_sel, t);
      end else if (ms == 1 && t < 2 * DEPTH) begin
        e_ena = 1; e_addr = 16'(t - DEPTH);
      end
      checks++;
      if (mem_ena !== e_ena || mem_wea !== e_wea || mem_addra !== e_addr ||
          mem_dina !== e_dina || busy !== e_busy || done !== e_done ||
          pass !== e_pass || err_cnt !== m_err[2:0] ||
          first_err_addr !== m_ferr[15:0]) begin
        errors++;
        $display("FAIL cycle @%0t got ena%b wea%b a%h d%h b%b dn%b p%b e%0d f%0d want ena%b wea%b a%h d%h b%b dn%b p%b e%0d f%0d",
          $time, mem_ena, mem_wea, mem_addra, mem_dina, busy, done, pass,
          err_cnt, first_err_addr, e_ena, e_wea, e_addr, e_dina, e_busy,
          e_done, e_pass, m_err, m_ferr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {mem_ena, mem_wea, busy, done, pass, err_cnt, mem_addra,
               mem_dina, first_err_addr}, 32'h0);
    chk({name, "_hi"}, {16'h0, mem_dina | first_err_addr}, 32'h0);
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(negedge clk);
    start = 1'b1;
    pattern_sel = sel;
    @(negedge clk);
    start = 1'b0;
    pattern_sel = 2'd0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset_init");
    rst = 1'b0;

    // async reset mid-write
    pulse_start(2'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async_write");
    #1 rst = 1'b0;

    // clean run, latency 33 edges after start edge
    pulse_start(2'd0);
    run_to_done(n);
    chk("latency", 32'(n), 32'd33);
    chk("clean_pass", {29'h0, pass, done, err_cnt == 3'd0}, 32'h7);
    chk("clean_ferr", 32'(first_err_addr), 32'd0);
    for (int i = 0; i < DEPTH; i++)
      chk("ram_content", 32'(ram[i]), 32'(i));

    // two corrupted reads
    corrupt[5] = 1'b1;
    corrupt[9] = 1'b1;
    pulse_start(2'd2);
    run_to_done(n);
    chk("two_err_cnt", 32'(err_cnt), 32'd2);
    chk("two_err_ferr", 32'(first_err_addr), 32'd5);
    chk("two_err_pass", 32'(pass), 32'd0);
    chk("ram_pat2_a4", 32'(ram[4]), 32'h0000AAAA);

    // every read corrupted: counter saturates
    corrupt = '1;
    pulse_start(2'd2);
    run_to_done(n);
    chk("sat_err_cnt", 32'(err_cnt), 32'd7);
    chk("sat_ferr", 32'(first_err_addr), 32'd0);
    corrupt = '0;

    // abort at WRITE addr 7
    pulse_start(2'd1);
    repeat (7) @(negedge clk);
    chk("pre_abort_addr", 32'(mem_addra), 32'd7);
    chk("pre_abort_dina", 32'(mem_dina), 32'h0000FFF8);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_idle", {29'h0, mem_ena, done, busy}, 32'h0);
    @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    pulse_start(2'd3);
    run_to_done(n);
    chk("rerun_latency", 32'(n), 32'd33);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("ram_seed", 32'(ram[11]), 32'h0000A5C3);

    // start pulses during READ ignored; restart from DONE
    corrupt[3] = 1'b1;
    pulse_start(2'd0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(n);
    chk("ignored_start_n", 32'(n), 32'd10);
    chk("ignored_start_err", 32'(err_cnt), 32'd1);
    chk("ignored_start_ferr", 32'(first_err_addr), 32'd3);
    corrupt = '0;
    pulse_start(2'd0);
    chk("restart_cleared", {28'h0, done, err_cnt}, 32'h0);
    chk("restart_write0", {15'h0, mem_wea, mem_addra}, 32'h00010000);
    run_to_done(n);
    chk("restart_pass", 32'(pass), 32'd1);

    // async reset during READ addr 10
    pulse_start(2'd0);
    repeat (26) @(negedge clk);
    chk("read10_addr", {15'h0, mem_wea, mem_addra}, 32'd10);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async_read");
    #1 rst = 1'b0;
    pulse_start(2'd2);
    run_to_done(n);
    chk("post_rst_latency", 32'(n), 32'd33);
    chk("post_rst_pass", 32'(pass), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
